dac_setpoint_ctrl: RTL and testbench
====================================

DAC_SETPOINT_CTRL -- requirements
Module: dac_setpoint_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, DAC code width (range 8..16).
REQ-002 SHALL provide parameter CH_N, default 2, number of DAC channels (range 2..16).
REQ-003 SHALL provide parameter COARSE_STEP, default 85, coarse-mode step size.
REQ-004 SHALL provide parameter HOLD_CNT, default 50000, auto-repeat interval and initial hold delay, in clk cycles.
REQ-005 SHALL provide parameter SCLK_DIV, default 2, clk cycles per serial clock half-period (minimum 1).
REQ-006 SHALL provide parameter CMD, default 4'h3, DAC command nibble.
REQ-007 SHALL provide port clk, input, 1 bit, the single clock. Reset is asynchronous and active-high.
REQ-008 SHALL provide port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL provide port iChSel, input, $clog2(CH_N) bits, selected channel index.
REQ-010 SHALL provide ports iUp, iDwn and iMid, each input, 1 bit, debounced button levels.
REQ-011 SHALL provide port iCoarse, input, 1 bit: 1 = coarse step mode, 0 = fine step mode.
REQ-012 SHALL provide port oData, output, CH_N*DATA_W bits, current setpoints; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL provide port oBusy, output, 1 bit, high while a serial frame is in progress.
REQ-014 SHALL provide ports oSync, oScl, oSda and oLdac, each output, 1 bit, DAC serial interface.

Function
REQ-015 SHALL detect rising edges of iUp, iDwn and iMid; each edge SHALL apply one step to channel iChSel, registered one cycle after the edge.
REQ-016 SHALL resolve simultaneous events by priority Mid > Up > Dwn; only one update SHALL occur per cycle.
REQ-017 Fine mode: Up SHALL add 1 and Dwn SHALL subtract 1, wrapping modulo 2^DATA_W; Mid SHALL load 2^(DATA_W-1).
REQ-018 Coarse mode, with CMAX = largest multiple of COARSE_STEP that is <= 2^DATA_W-1:
- Up from a value >= CMAX SHALL give 0; otherwise value + COARSE_STEP.
- Dwn from 0 SHALL give CMAX; from a value < COARSE_STEP SHALL give 0; otherwise value - COARSE_STEP.
- Mid SHALL load the largest multiple of COARSE_STEP that is <= 2^(DATA_W-1).
REQ-019 In fine mode, while iUp or iDwn stays high for HOLD_CNT cycles, the block SHALL apply a repeat step, then one further step every HOLD_CNT cycles; release SHALL clear the hold counter. There SHALL be no auto-repeat in coarse mode.
REQ-020 Any setpoint write SHALL set that channel's dirty flag, even when the value is unchanged.
REQ-021 Frame FSM states SHALL be IDLE, SYNC, SHIFT, LDAC.
- IDLE -> SYNC when any dirty flag is set; the lowest-index dirty channel is chosen, its flag is cleared and its value is captured.
- SYNC: oSync SHALL go low for 1 cycle.
- SHIFT: 24 bits SHALL be sent MSB first: {CMD, 4-bit channel index, value left-justified in 16 bits}. oSda SHALL change on falling oScl. Each oScl half-period SHALL be SCLK_DIV cycles.
- LDAC: oSync SHALL go high, then oLdac SHALL go low for exactly 1 cycle, then the FSM SHALL return to IDLE.
REQ-022 A write to a channel during its own frame SHALL re-set its dirty flag; the frame in progress SHALL keep the captured value.
REQ-023 oBusy SHALL be high in SYNC, SHIFT and LDAC.

Reset
REQ-024 While rst is high, every setpoint, dirty flag and hold counter SHALL be 0, and the FSM SHALL be IDLE. Outputs SHALL be: oSync=1, oScl=0, oSda=0, oLdac=1, oBusy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; oLdac SHALL NOT pulse.

Configuration
REQ-026 With macro DAC_SETPOINT_RAMP_EN defined, the block SHALL add input iRamp. While iRamp is high, channel iChSel SHALL step by 1 every HOLD_CNT cycles as a triangle wave, reversing direction at 0 and at 2^DATA_W-1; button steps SHALL take priority in the same cycle.
REQ-027 Without DAC_SETPOINT_RAMP_EN, the iRamp port and all ramp logic SHALL be absent.

Verification (DATA_W=12, CH_N=2, HOLD_CNT=16, SCLK_DIV=2)
REQ-028 Reset, then Mid pulse on ch1 in fine mode -> oData ch1 = 2048; frame bits = 0x318000; one oLdac low pulse.
REQ-029 Coarse mode on ch0 = 0: Dwn -> 4080; Up -> 0; Mid -> 2040.
REQ-030 Fine mode, Dwn pulse at 0 -> 4095; hold iUp for 50 cycles -> 3 additional repeat steps.
REQ-031 Up on ch0 and ch1 in consecutive cycles -> two frames, ch0 first; oBusy stays high between them except for at least 1 IDLE cycle.
REQ-032 Assert rst at bit 10 of a frame -> oSync=1 and oLdac=1 at once; no oLdac pulse; setpoints = 0.
REQ-033 With DAC_SETPOINT_RAMP_EN defined and iRamp high from 4094 -> 4095, then 4094 at 16-cycle spacing.

Source files
------------

// File: rtl/dac_setpoint_ctrl.sv
// dac_setpoint_ctrl: button-driven multi-channel DAC setpoints streamed out as 24-bit serial frames.
// Define DAC_SETPOINT_RAMP_EN to add the iRamp triangle-wave sweep on the selected channel.
module dac_setpoint_ctrl #(
    parameter int DATA_W = 12,
    parameter int CH_N = 2,
    parameter int COARSE_STEP = 85,
    parameter int HOLD_CNT = 50000,
    parameter int SCLK_DIV = 2,
    parameter logic [3:0] CMD = 4'h3
) (
    input  logic clk,
    input  logic rst,
    input  logic [$clog2(CH_N)-1:0] iChSel,
    input  logic iUp,
    input  logic iDwn,
    input  logic iMid,
    input  logic iCoarse,
`ifdef DAC_SETPOINT_RAMP_EN
    input  logic iRamp,
`endif
    output logic [CH_N*DATA_W-1:0] oData,
    output logic oBusy,
    output logic oSync,
    output logic oScl,
    output logic oSda,
    output logic oLdac
);
    localparam int CW = $clog2(CH_N);
    localparam int HW = $clog2(HOLD_CNT + 1);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int MAXV = (1 << DATA_W) - 1;
    localparam logic [DATA_W-1:0] CMAX = DATA_W'((MAXV / COARSE_STEP) * COARSE_STEP);
    localparam logic [DATA_W-1:0] CMID = DATA_W'(((1 << (DATA_W - 1)) / COARSE_STEP) * COARSE_STEP);
    localparam logic [DATA_W-1:0] FMID = DATA_W'(1 << (DATA_W - 1));
    localparam logic [DATA_W-1:0] STEP = DATA_W'(COARSE_STEP);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, LDAC} state_t;

    logic [DATA_W-1:0] sp [CH_N];
    logic [DATA_W-1:0] cur, nxt, c_up, c_dn, ramp_val;
    logic [CH_N-1:0] dirty, dirty_n;
    logic [HW-1:0] hold;
    logic up_q, dwn_q, mid_q, up_e, dwn_e, mid_e, held, rep, wr, sel_ok, ramp_go, rdn_n;
    logic [CW-1:0] pick;
    logic [15:0] lj;
    logic [23:0] word, sh;
    state_t state;
    logic [DW-1:0] div;
    logic [4:0] bitn;
`ifdef DAC_SETPOINT_RAMP_EN
    logic [HW-1:0] rtmr;
    logic rdn;
`endif

    always_comb begin
        up_e = iUp & ~up_q;
        dwn_e = iDwn & ~dwn_q;
        mid_e = iMid & ~mid_q;
        sel_ok = 32'(iChSel) < CH_N;
        cur = sp[iChSel];
        held = ~iCoarse & (iUp | iDwn);
        rep = held & (hold == HW'(HOLD_CNT - 1));
        c_up = cur >= CMAX ? '0 : cur + STEP;
        c_dn = cur == '0 ? CMAX : cur < STEP ? '0 : cur - STEP;
`ifdef DAC_SETPOINT_RAMP_EN
        ramp_go = iRamp & (rtmr == HW'(HOLD_CNT - 1));
        rdn_n = cur == '1 ? 1'b1 : cur == '0 ? 1'b0 : rdn;
`else
        ramp_go = 1'b0;
        rdn_n = 1'b0;
`endif
        ramp_val = rdn_n ? cur - 1'b1 : cur + 1'b1;
        wr = sel_ok & (mid_e | up_e | dwn_e | rep | ramp_go);
        nxt = mid_e ? (iCoarse ? CMID : FMID) :
              up_e  ? (iCoarse ? c_up : cur + 1'b1) :
              dwn_e ? (iCoarse ? c_dn : cur - 1'b1) :
              rep   ? (iUp ? cur + 1'b1 : cur - 1'b1) : ramp_val;
        pick = '0;
        for (int i = CH_N - 1; i >= 0; i--)
            if (dirty[i]) pick = CW'(i);
        lj = 16'(sp[pick]) << (16 - DATA_W);
        word = {CMD, 4'(pick), lj};
        dirty_n = dirty;
        if (state == IDLE && |dirty) dirty_n[pick] = 1'b0;
        // A write landing on the channel being captured must win so it is sent again.
        if (wr) dirty_n[iChSel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_N; i++) sp[i] <= '0;
            dirty <= '0;
            hold <= '0;
            {up_q, dwn_q, mid_q} <= '0;
`ifdef DAC_SETPOINT_RAMP_EN
            rtmr <= '0;
            rdn <= 1'b0;
`endif
        end else begin
            {up_q, dwn_q, mid_q} <= {iUp, iDwn, iMid};
            hold <= held & ~rep ? hold + 1'b1 : '0;
            dirty <= dirty_n;
            if (wr) sp[iChSel] <= nxt;
`ifdef DAC_SETPOINT_RAMP_EN
            rtmr <= iRamp & ~ramp_go ? rtmr + 1'b1 : '0;
            if (wr & ramp_go & ~(mid_e | up_e | dwn_e | rep)) rdn <= rdn_n;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh <= '0;
            div <= '0;
            bitn <= '0;
            oSync <= 1'b1;
            oScl <= 1'b0;
            oSda <= 1'b0;
            oLdac <= 1'b1;
            oBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|dirty) begin
                    state <= SYNC;
                    sh <= word;
                    oSda <= word[23];
                    oSync <= 1'b0;
                    oBusy <= 1'b1;
                    div <= '0;
                    bitn <= '0;
                end
                SYNC: state <= SHIFT;
                SHIFT: if (div == DW'(SCLK_DIV - 1)) begin
                    div <= '0;
                    oScl <= ~oScl;
                    // Data only moves on the falling serial clock.
                    if (oScl) begin
                        if (bitn == 5'd23) begin
                            state <= LDAC;
                            oSync <= 1'b1;
                            oSda <= 1'b0;
                        end else begin
                            bitn <= bitn + 1'b1;
                            sh <= {sh[22:0], 1'b0};
                            oSda <= sh[22];
                        end
                    end
                end else div <= div + 1'b1;
                LDAC: if (oLdac) oLdac <= 1'b0;
                else begin
                    oLdac <= 1'b1;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < CH_N; k++) begin : g_out
        assign oData[k*DATA_W +: DATA_W] = sp[k];
    end
endmodule

// File: tb/tb_dac_setpoint_ctrl.sv
// tb_dac_setpoint_ctrl: random button stimulus against an arithmetic setpoint model plus a serial frame monitor.
module tb_dac_setpoint_ctrl;
    localparam int W = 12, N = 2, CS = 85, HC = 16, SD = 2;
    localparam logic [3:0] CMD = 4'h3;
    localparam int M = 1 << W;

    logic clk = 0, rst = 1, iUp = 0, iDwn = 0, iMid = 0, iCoarse = 0, iRamp = 0;
    logic [0:0] iChSel = 0;
    logic [N*W-1:0] oData;
    logic oBusy, oSync, oScl, oSda, oLdac;

    dac_setpoint_ctrl #(.DATA_W(W), .CH_N(N), .COARSE_STEP(CS), .HOLD_CNT(HC), .SCLK_DIV(SD), .CMD(CMD)) dut (
        .clk(clk), .rst(rst), .iChSel(iChSel), .iUp(iUp), .iDwn(iDwn), .iMid(iMid), .iCoarse(iCoarse),
`ifdef DAC_SETPOINT_RAMP_EN
        .iRamp(iRamp),
`endif
        .oData(oData), .oBusy(oBusy), .oSync(oSync), .oScl(oScl), .oSda(oSda), .oLdac(oLdac)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int sp_m [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int mstep(input int v, input bit coarse, input int kind);
        int cmax = ((M - 1) / CS) * CS;
        if (kind == 0) return coarse ? ((M / 2) / CS) * CS : M / 2;
        if (kind == 1) return coarse ? (v >= cmax ? 0 : (v + CS) % M) : (v + 1) % M;
        return coarse ? (v == 0 ? cmax : v < CS ? 0 : v - CS) : (v + M - 1) % M;
    endfunction

    function automatic logic [31:0] chv(input int c);
        return 32'(oData[c*W +: W]);
    endfunction

    function automatic logic [23:0] efr(input int c, input int v);
        return {CMD, 4'(c), 16'(v << (16 - W))};
    endfunction

    // Serial monitor: rebuilds frames from scl rises and checks pulse shapes.
    logic [23:0] fr = 0;
    logic [23:0] last_fr [16];
    logic [23:0] fr_q [$];
    int nb = 0, ldac_n = 0, lw = 0, busy_rise = 0, sda_bad = 0, fr_bad = 0, ldac_bad = 0;
    logic pscl = 0, psda = 0, pldac = 1, psync = 1, pbusy = 0;

    always @(negedge clk) begin
        if (rst) begin
            nb <= 0; lw <= 0;
            pscl <= 0; psda <= 0; pldac <= 1; psync <= 1; pbusy <= 0;
        end else begin
            pscl <= oScl; psda <= oSda; pldac <= oLdac; psync <= oSync; pbusy <= oBusy;
            if (psync && !oSync) nb <= 0;
            if (!oSync && oScl && !pscl) begin
                fr <= {fr[22:0], oSda};
                nb <= nb + 1;
            end
            if (oScl && pscl && oSda !== psda) sda_bad <= sda_bad + 1;
            if (!oLdac && pldac) begin
                ldac_n <= ldac_n + 1;
                if (nb != 24 || !oSync) fr_bad <= fr_bad + 1;
                last_fr[fr[19:16]] <= fr;
                fr_q.push_back(fr);
            end
            lw <= oLdac ? 0 : lw + 1;
            if (oLdac && !pldac && lw != 1) ldac_bad <= ldac_bad + 1;
            if (oBusy && !pbusy) busy_rise <= busy_rise + 1;
        end
    end

    task automatic press(input int ch, input bit coarse, input bit m, input bit u, input bit d, input int cyc);
        @(negedge clk);
        iChSel = 1'(ch); iCoarse = coarse; iMid = m; iUp = u; iDwn = d;
        if (m || u || d) sp_m[ch] = mstep(sp_m[ch], coarse, m ? 0 : u ? 1 : 2);
        if (!coarse && !m && (u || d))
            for (int i = 0; i < (cyc - 1) / HC; i++) sp_m[ch] = mstep(sp_m[ch], 0, u ? 1 : 2);
        repeat (cyc) @(negedge clk);
        check($sformatf("ch%0d_value", ch), chv(ch), sp_m[ch]);
        iMid = 0; iUp = 0; iDwn = 0;
    endtask

    task automatic wait_idle();
        int q = 0, t = 0;
        while (q < 4 && t < 5000) begin
            @(negedge clk);
            q = oBusy ? 0 : q + 1;
            t++;
        end
        if (t >= 5000) check("idle_timeout", 1, 0);
    endtask

    initial begin
        logic [23:0] f0, f1;
        int b0, l0, t;
        foreach (sp_m[i]) sp_m[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_sync", oSync, 1);
        check("rst_scl", oScl, 0);
        check("rst_sda", oSda, 0);
        check("rst_ldac", oLdac, 1);
        check("rst_busy", oBusy, 0);
        check("rst_data", oData, 0);
        rst = 0;

        press(1, 0, 1, 0, 0, 1);
        wait_idle();
        check("mid_frames", fr_q.size(), 1);
        f0 = fr_q.size() > 0 ? fr_q[0] : 24'h0;
        check("mid_frame_bits", f0, 24'h318000);
        check("mid_ldac_pulses", ldac_n, 1);

        press(0, 1, 0, 0, 1, 1);
        press(0, 1, 0, 1, 0, 1);
        press(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 24; i++) press(0, 1, 0, 0, 1, 1);
        press(0, 0, 0, 0, 1, 1);
        press(0, 0, 0, 1, 0, 50);
        press(0, 1, 0, 1, 0, 40);

        wait_idle();
        fr_q.delete();
        b0 = busy_rise;
        press(0, 0, 0, 1, 0, 1);
        press(1, 0, 0, 1, 0, 1);
        wait_idle();
        check("pair_frames", fr_q.size(), 2);
        f0 = fr_q.size() > 0 ? fr_q[0] : 24'h0;
        f1 = fr_q.size() > 1 ? fr_q[1] : 24'h0;
        check("pair_first", f0, efr(0, sp_m[0]));
        check("pair_second", f1, efr(1, sp_m[1]));
        check("pair_busy_gap", busy_rise - b0, 2);

        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(1, 7);
            press($urandom_range(0, 1), 1'($urandom_range(0, 1)), r[2], r[1], r[0], $urandom_range(1, 4));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        press(0, 0, 0, 1, 0, 1);
        press(1, 0, 0, 0, 1, 1);
        wait_idle();
        for (int c = 0; c < N; c++) check($sformatf("last_frame_ch%0d", c), last_fr[c], efr(c, sp_m[c]));
        check("frame_len", fr_bad, 0);
        check("sda_stable", sda_bad, 0);
        check("ldac_width", ldac_bad, 0);

        press(0, 0, 0, 1, 0, 1);
        for (t = 0; t < 1000 && nb != 10; t++) @(negedge clk);
        check("bit10_reached", nb, 10);
        #2 rst = 1;
        #1;
        check("abort_sync", oSync, 1);
        check("abort_ldac", oLdac, 1);
        check("abort_busy", oBusy, 0);
        check("abort_data", oData, 0);
        l0 = ldac_n;
        repeat (3) @(negedge clk);
        rst = 0;
        foreach (sp_m[i]) sp_m[i] = 0;
        repeat (200) @(negedge clk);
        check("abort_no_ldac", ldac_n, l0);
        check("abort_idle", oBusy, 0);

`ifdef DAC_SETPOINT_RAMP_EN
        press(0, 0, 0, 0, 1, 1);
        press(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        iChSel = 0; iRamp = 1;
        repeat (16) @(negedge clk);
        check("ramp_top", chv(0), 4095);
        repeat (16) @(negedge clk);
        check("ramp_reverse", chv(0), 4094);
        iRamp = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
